// File: rtl/proc_dbg_pkg.sv
// Shared encodings for the Processador run/debug sequencer: FSM states, run modes, halt causes.
package proc_dbg_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_HALTED = 3'd2;
  localparam logic [2:0] ST_FAULT  = 3'd3;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_STEP  = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_BUDGET   = 3'd1;
  localparam logic [2:0] CAUSE_BREAK    = 3'd2;
  localparam logic [2:0] CAUSE_HALT_REQ = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT  = 3'd4;

endpackage

// File: rtl/proc_bp_match.sv
// PC breakpoint slots and comparator bank; reports whether any valid slot matches the PC and
// the lowest matching slot index.
module proc_bp_match
  import proc_dbg_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int NUM_BP = 4,
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [PC_W-1:0]  addr,
  input  logic             en,
  input  logic [PC_W-1:0]  pc,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx
);

  logic [PC_W-1:0]   slot_addr [NUM_BP];
  logic [NUM_BP-1:0] slot_valid;

  // Address storage needs no reset: the valid bits gate every match.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      slot_valid <= '0;
    end else if (we && (int'(idx) < NUM_BP)) begin
      slot_addr[idx]  <= addr;
      slot_valid[idx] <= en;
    end
  end

  // Scan from the top so the lowest matching slot is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (slot_valid[i] && (slot_addr[i] == pc)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/proc_run_controller.sv
// Run/debug sequencer for the multicycle Processador core: gates Run/clock-enable, counts
// instructions and cycles, and stops the core at instruction boundaries.
//
//   state  | meaning
//   IDLE   | core stopped, counters cleared or preserved from reset
//   RUN    | core enabled, counting cycles, watching Done for stop conditions
//   HALTED | stopped at an instruction boundary, halt_cause tells why
//   FAULT  | watchdog expired mid-instruction, only clear or reset leave
module proc_run_controller
  import proc_dbg_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int NUM_BP   = 4,
  parameter int CNT_W    = 32,
  parameter int BUDGET_W = 16,
  parameter int TIMEOUT  = 64,
  localparam int IDX_W   = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [BUDGET_W-1:0] n_instr,
  input  logic                halt,
  input  logic                clear,
  input  logic                bp_we,
  input  logic [IDX_W-1:0]    bp_idx,
  input  logic [PC_W-1:0]     bp_addr,
  input  logic                bp_en,
  input  logic                core_done,
  input  logic [PC_W-1:0]     core_pc,
  output logic                core_run,
  output logic                core_ce,
  output logic [2:0]          state,
  output logic [2:0]          halt_cause,
  output logic [IDX_W-1:0]    bp_hit_idx,
  output logic [CNT_W-1:0]    instr_count,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [7:0]          last_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       WD_LAST = 8'(TIMEOUT - 1);

  logic [BUDGET_W-1:0] budget;
  logic [BUDGET_W-1:0] budget_dec;
  logic                budget_en;
  logic                halt_pending;
  logic [7:0]          cur_cycles;
  logic                bp_hit;
  logic [IDX_W-1:0]    bp_hit_w;
  logic                stop_now;
  logic [2:0]          stop_cause;
  logic                do_clear;

  proc_bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .we      (bp_we),
    .idx     (bp_idx),
    .addr    (bp_addr),
    .en      (bp_en),
    .pc      (core_pc),
    .hit     (bp_hit),
    .hit_idx (bp_hit_w)
  );

  assign core_run   = (state == ST_RUN);
  assign core_ce    = core_run;
  assign budget_dec = budget_en ? (budget - BUDGET_W'(1)) : budget;
  assign do_clear   = clear && ((state == ST_HALTED) || (state == ST_FAULT));

  always_comb begin
    stop_now   = 1'b0;
    stop_cause = CAUSE_NONE;
    if (halt_pending || halt) begin
      stop_now   = 1'b1;
      stop_cause = CAUSE_HALT_REQ;
    end else if (budget_en && (budget_dec == '0)) begin
      stop_now   = 1'b1;
      stop_cause = CAUSE_BUDGET;
    end else if (bp_hit) begin
      stop_now   = 1'b1;
      stop_cause = CAUSE_BREAK;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state        <= ST_IDLE;
      halt_cause   <= CAUSE_NONE;
      bp_hit_idx   <= '0;
      instr_count  <= '0;
      cycle_count  <= '0;
      last_cycles  <= '0;
      cur_cycles   <= '0;
      budget       <= '0;
      budget_en    <= 1'b0;
      halt_pending <= 1'b0;
    end else if (do_clear) begin
      state        <= ST_IDLE;
      halt_cause   <= CAUSE_NONE;
      bp_hit_idx   <= '0;
      instr_count  <= '0;
      cycle_count  <= '0;
      last_cycles  <= '0;
      cur_cycles   <= '0;
      halt_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            halt_cause   <= CAUSE_NONE;
            bp_hit_idx   <= '0;
            halt_pending <= 1'b0;
            cur_cycles   <= '0;
            case (mode)
              MODE_STEP: begin
                budget    <= BUDGET_W'(1);
                budget_en <= 1'b1;
                state     <= ST_RUN;
              end
              MODE_COUNT: begin
                // An empty budget is already exhausted: report it without enabling the core.
                if (n_instr == '0) begin
                  budget_en  <= 1'b0;
                  halt_cause <= CAUSE_BUDGET;
                  state      <= ST_HALTED;
                end else begin
                  budget    <= n_instr;
                  budget_en <= 1'b1;
                  state     <= ST_RUN;
                end
              end
              default: begin
                budget_en <= 1'b0;
                state     <= ST_RUN;
              end
            endcase
          end
        end

        ST_RUN: begin
          if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_W'(1);
          if (core_done) begin
            if (instr_count != CNT_MAX) instr_count <= instr_count + CNT_W'(1);
            last_cycles <= cur_cycles + 8'd1;
            cur_cycles  <= '0;
            budget      <= budget_dec;
            if (stop_now) begin
              state        <= ST_HALTED;
              halt_cause   <= stop_cause;
              bp_hit_idx   <= (stop_cause == CAUSE_BREAK) ? bp_hit_w : '0;
              halt_pending <= 1'b0;
            end
          end else if (cur_cycles == WD_LAST) begin
            state      <= ST_FAULT;
            halt_cause <= CAUSE_TIMEOUT;
          end else begin
            cur_cycles <= cur_cycles + 8'd1;
            if (halt) halt_pending <= 1'b1;
          end
        end

        ST_FAULT: ;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_run_controller.sv
// Bench for proc_run_controller: stub multicycle core, event-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_proc_run_controller;
  import proc_dbg_pkg::*;

  localparam int PC_W     = 16;
  localparam int NUM_BP   = 4;
  localparam int CNT_W    = 32;
  localparam int BUDGET_W = 16;
  localparam int TIMEOUT  = 64;
  localparam int IDX_W    = 2;

  logic                Clock = 1'b0;
  logic                Resetn = 1'b0;
  logic                start = 1'b0;
  logic [1:0]          mode = '0;
  logic [BUDGET_W-1:0] n_instr = '0;
  logic                halt = 1'b0;
  logic                clear = 1'b0;
  logic                bp_we = 1'b0;
  logic [IDX_W-1:0]    bp_idx = '0;
  logic [PC_W-1:0]     bp_addr = '0;
  logic                bp_en = 1'b0;
  logic                core_done;
  logic [PC_W-1:0]     core_pc;
  logic                core_run;
  logic                core_ce;
  logic [2:0]          state;
  logic [2:0]          halt_cause;
  logic [IDX_W-1:0]    bp_hit_idx;
  logic [CNT_W-1:0]    instr_count;
  logic [CNT_W-1:0]    cycle_count;
  logic [7:0]          last_cycles;

  proc_run_controller #(
    .PC_W(PC_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .BUDGET_W(BUDGET_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .mode(mode), .n_instr(n_instr),
    .halt(halt), .clear(clear), .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr),
    .bp_en(bp_en), .core_done(core_done), .core_pc(core_pc), .core_run(core_run),
    .core_ce(core_ce), .state(state), .halt_cause(halt_cause), .bp_hit_idx(bp_hit_idx),
    .instr_count(instr_count), .cycle_count(cycle_count), .last_cycles(last_cycles)
  );

  always #5 Clock = ~Clock;

  // Stub core: instruction at PC p takes len_tab[p mod 64] enabled cycles, PC += 1 per instr.
  logic [PC_W-1:0] s_pc = '0;
  int              s_cyc = 0;
  int              len_tab [64];
  logic            no_done = 1'b0;
  logic            stub_clr = 1'b0;

  assign core_done = core_ce && !no_done && (s_cyc >= len_tab[s_pc[5:0]] - 1);
  assign core_pc   = core_done ? s_pc + 16'd1 : s_pc;

  always @(posedge Clock) begin
    if (stub_clr) begin
      s_pc  <= '0;
      s_cyc <= 0;
    end else if (core_ce) begin
      if (core_done) begin
        s_pc  <= s_pc + 16'd1;
        s_cyc <= 0;
      end else begin
        s_cyc <= s_cyc + 1;
      end
    end
  end

  int ce_total = 0;
  always @(negedge Clock) if (core_ce === 1'b1) ce_total++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  typedef enum {P_IDLE, P_RUN, P_HALTED, P_FAULT} phase_t;
  localparam longint MAXC = 64'hFFFF_FFFF;

  phase_t m_ph = P_IDLE;
  longint m_ins = 0, m_cyc = 0;
  int     m_last = 0, m_cur = 0, m_cause = 0, m_bpidx = 0, m_left = 0;
  bit     m_limited = 0, m_hp = 0;
  bit [PC_W-1:0] m_ba [NUM_BP];
  bit            m_bv [NUM_BP];

  function automatic longint sat(input longint v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic int exp_state(input phase_t p);
    case (p)
      P_IDLE:   return 0;
      P_RUN:    return 1;
      P_HALTED: return 2;
      default:  return 3;
    endcase
  endfunction

  task m_zero();
    m_ph = P_IDLE; m_ins = 0; m_cyc = 0; m_last = 0; m_cur = 0;
    m_cause = 0; m_bpidx = 0; m_hp = 0;
  endtask

  task m_stop(input int cause, input int idx);
    m_ph = P_HALTED; m_cause = cause; m_bpidx = idx; m_hp = 0;
  endtask

  task m_start();
    m_cause = 0; m_bpidx = 0; m_hp = 0; m_cur = 0; m_ph = P_RUN;
    if (mode == 2'd1) begin
      m_limited = 1; m_left = 1;
    end else if (mode == 2'd2) begin
      m_limited = 1; m_left = int'(n_instr);
      if (m_left == 0) begin
        m_limited = 0; m_ph = P_HALTED; m_cause = 1;
      end
    end else begin
      m_limited = 0;
    end
  endtask

  always @(posedge Clock) begin
    if (!Resetn) begin
      m_zero();
      m_limited = 0; m_left = 0;
      for (int i = 0; i < NUM_BP; i++) m_bv[i] = 0;
    end else begin
      bit hit;
      int hidx;
      hit = 0; hidx = 0;
      for (int i = NUM_BP - 1; i >= 0; i--)
        if (m_bv[i] && m_ba[i] == core_pc) begin hit = 1; hidx = i; end
      case (m_ph)
        P_IDLE:   if (start) m_start();
        P_HALTED: if (clear) m_zero(); else if (start) m_start();
        P_FAULT:  if (clear) m_zero();
        default: begin
          m_cyc = sat(m_cyc + 1);
          if (core_done) begin
            m_ins  = sat(m_ins + 1);
            m_last = (m_cur + 1) % 256;
            m_cur  = 0;
            if (m_limited) m_left--;
            if (m_hp || halt)               m_stop(3, 0);
            else if (m_limited && m_left == 0) m_stop(1, 0);
            else if (hit)                   m_stop(2, hidx);
          end else if (m_cur == TIMEOUT - 1) begin
            m_ph = P_FAULT; m_cause = 4;
          end else begin
            m_cur++;
            if (halt) m_hp = 1;
          end
        end
      endcase
      if (bp_we) begin m_ba[bp_idx] = bp_addr; m_bv[bp_idx] = bp_en; end
    end
  end

  bit chk_en = 0;
  always @(negedge Clock) if (chk_en) begin
    chk("state",       state,       exp_state(m_ph));
    chk("core_ce",     core_ce,     m_ph == P_RUN);
    chk("core_run",    core_run,    m_ph == P_RUN);
    chk("halt_cause",  halt_cause,  m_cause);
    chk("bp_hit_idx",  bp_hit_idx,  m_bpidx);
    chk("instr_count", instr_count, m_ins);
    chk("cycle_count", cycle_count, m_cyc);
    chk("last_cycles", last_cycles, m_last);
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic [1:0] md, input int n);
    start = 1'b1; mode = md; n_instr = BUDGET_W'(n);
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge Clock);
    clear = 1'b0;
  endtask

  task automatic stub_reset();
    stub_clr = 1'b1;
    @(negedge Clock);
    stub_clr = 1'b0;
  endtask

  task automatic write_bp(input int idx, input int addr, input bit en);
    bp_we = 1'b1; bp_idx = IDX_W'(idx); bp_addr = PC_W'(addr); bp_en = en;
    @(negedge Clock);
    bp_we = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int max, input string nm);
    int k;
    k = 0;
    while (state !== tgt && k < max) begin
      @(negedge Clock);
      k++;
    end
    chk(nm, state, tgt);
  endtask

  int ce0;

  initial begin
    for (int i = 0; i < 64; i++) len_tab[i] = 4;
    stub_clr = 1'b1;
    repeat (2) @(negedge Clock);
    chk_en = 1;
    chk("rst_state", state, 0);
    chk("rst_ce", core_ce, 0);
    chk("rst_instr", instr_count, 0);
    Resetn = 1'b1;
    stub_clr = 1'b0;

    // single step of a 6-cycle instruction
    len_tab[0] = 6;
    ce0 = ce_total;
    pulse_start(MODE_STEP, 0);
    wait_state(ST_HALTED, 40, "step_halted");
    chk("step_ce_cycles", ce_total - ce0, 6);
    chk("step_cause", halt_cause, 1);
    chk("step_instr", instr_count, 1);
    chk("step_cycles", cycle_count, 6);
    chk("step_last", last_cycles, 6);

    // run-3 over lengths 4,6,6
    pulse_clear();
    stub_reset();
    len_tab[0] = 4; len_tab[1] = 6; len_tab[2] = 6;
    ce0 = ce_total;
    pulse_start(MODE_COUNT, 3);
    wait_state(ST_HALTED, 60, "count_halted");
    chk("count_ce_cycles", ce_total - ce0, 16);
    chk("count_instr", instr_count, 3);
    chk("count_cycles", cycle_count, 16);
    chk("count_cause", halt_cause, 1);

    // run-0 never enables the core
    pulse_clear();
    ce0 = ce_total;
    pulse_start(MODE_COUNT, 0);
    repeat (3) @(negedge Clock);
    chk("count0_state", state, 2);
    chk("count0_cause", halt_cause, 1);
    chk("count0_ce_cycles", ce_total - ce0, 0);

    // breakpoints: stop at PC 5, then resume to a shared address hitting slots 1 and 2
    pulse_clear();
    stub_reset();
    for (int i = 0; i < 64; i++) len_tab[i] = 4;
    write_bp(0, 5, 1);
    pulse_start(MODE_FREE, 0);
    wait_state(ST_HALTED, 100, "bp_halted");
    chk("bp_cause", halt_cause, 2);
    chk("bp_idx", bp_hit_idx, 0);
    chk("bp_instr", instr_count, 5);
    write_bp(2, 8, 1);
    write_bp(1, 8, 1);
    pulse_start(MODE_FREE, 0);
    wait_state(ST_HALTED, 100, "bp_resume_halted");
    chk("bp_resume_cause", halt_cause, 2);
    chk("bp_resume_idx", bp_hit_idx, 1);
    chk("bp_resume_instr", instr_count, 8);

    // halt request mid-instruction, then coincident with the budget end
    for (int i = 0; i < NUM_BP; i++) write_bp(i, 0, 0);
    pulse_clear();
    stub_reset();
    len_tab[0] = 6; len_tab[1] = 6;
    pulse_start(MODE_FREE, 0);
    @(negedge Clock);
    halt = 1'b1;
    @(negedge Clock);
    halt = 1'b0;
    wait_state(ST_HALTED, 40, "halt_halted");
    chk("halt_cause", halt_cause, 3);
    chk("halt_instr", instr_count, 1);
    chk("halt_last", last_cycles, 6);
    pulse_start(MODE_STEP, 0);
    repeat (5) @(negedge Clock);
    halt = 1'b1;
    @(negedge Clock);
    halt = 1'b0;
    chk("halt_budget_state", state, 2);
    chk("halt_budget_cause", halt_cause, 3);
    chk("halt_budget_instr", instr_count, 2);

    // watchdog
    pulse_clear();
    stub_reset();
    no_done = 1'b1;
    ce0 = ce_total;
    pulse_start(MODE_FREE, 0);
    wait_state(ST_FAULT, 100, "wd_fault");
    chk("wd_ce_cycles", ce_total - ce0, 64);
    chk("wd_cause", halt_cause, 4);
    chk("wd_cycles", cycle_count, 64);
    pulse_start(MODE_FREE, 0);
    repeat (2) @(negedge Clock);
    chk("wd_start_ignored", state, 3);
    pulse_clear();
    chk("wd_clear_state", state, 0);
    chk("wd_clear_cycles", cycle_count, 0);
    chk("wd_clear_cause", halt_cause, 0);
    no_done = 1'b0;

    // reset in the middle of a run
    stub_reset();
    pulse_start(MODE_FREE, 0);
    repeat (3) @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    chk("midrst_state", state, 0);
    chk("midrst_ce", core_ce, 0);
    chk("midrst_cycles", cycle_count, 0);
    Resetn = 1'b1;

    // randomized traffic, including lengths right at the watchdog limit
    stub_reset();
    for (int i = 0; i < 64; i++) begin
      case ($urandom % 32)
        0:       len_tab[i] = 1;
        1:       len_tab[i] = TIMEOUT - 1;
        2:       len_tab[i] = TIMEOUT;
        3:       len_tab[i] = TIMEOUT + 1;
        default: len_tab[i] = ($urandom % 2) ? 4 : 6;
      endcase
    end
    repeat (4000) begin
      Resetn  = ($urandom % 400) != 0;
      start   = ($urandom % 12) == 0;
      mode    = 2'($urandom % 4);
      n_instr = BUDGET_W'($urandom % 4);
      halt    = ($urandom % 40) == 0;
      clear   = ($urandom % 30) == 0;
      bp_we   = ($urandom % 15) == 0;
      bp_idx  = IDX_W'($urandom % NUM_BP);
      bp_addr = s_pc + PC_W'($urandom % 6);
      bp_en   = ($urandom % 4) != 0;
      @(negedge Clock);
    end
    Resetn = 1'b1; start = 0; halt = 0; clear = 0; bp_we = 0;
    @(negedge Clock);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got %0t expected < 2000000", $time);
    $fatal(1, "global timeout");
  end

endmodule
